k_sync_fifo: RTL and testbench

Parametrised single-clock first-word-fall-through FIFO. It generalises the fixed two-entry dual-port buffer to 2^ADDR_SIZE entries of any width, with internal pointer management, occupancy count, full/empty and programmable almost flags, and error pulses. It sits between producer and consumer stages in the same clock domain as the standard buffering element of the FIFO library.

---
 rtl/k_sync_fifo_if.sv | 28 ++
 rtl/k_sync_fifo.sv | 76 +++++++
 tb/tb_k_sync_fifo.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/k_sync_fifo_if.sv
// Handshake and status bundle for k_sync_fifo; the master side is the producer/consumer,
// the slave side is the FIFO itself.
interface k_sync_fifo_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 2
);
  logic                 wen;
  logic [DATA_SIZE-1:0] d;
  logic                 ren;
  logic [DATA_SIZE-1:0] q;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_SIZE:0]   count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wen, d, ren,
    input  q, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wen, d, ren,
    output q, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/k_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with 2^ADDR_SIZE entries, occupancy count,
// registered full/empty/almost flags and one-cycle overflow/underflow pulses.
module k_sync_fifo #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned ADDR_SIZE    = 2,
  parameter int unsigned AFULL_LEVEL  = (1 << ADDR_SIZE) - 1,
  parameter int unsigned AEMPTY_LEVEL = 1
) (
  input logic         clk,
  input logic         rst,
  k_sync_fifo_if.slave bus_io
);
  localparam int unsigned Depth = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DepthCnt  = (ADDR_SIZE + 1)'(Depth);
  localparam logic [ADDR_SIZE:0] AfullCnt  = (ADDR_SIZE + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_SIZE:0] AemptyCnt = (ADDR_SIZE + 1)'(AEMPTY_LEVEL);

  logic [DATA_SIZE-1:0] mem_q [Depth];
  logic [ADDR_SIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic                 full_q, empty_q, afull_q, aempty_q;
  logic                 overflow_q, underflow_q;
  logic                 wr_ok, rd_ok;

  // A full FIFO still accepts a write when the same cycle frees a slot by reading.
  assign wr_ok = bus_io.wen && (!full_q || bus_io.ren);
  assign rd_ok = bus_io.ren && !empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == DepthCnt);
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= AfullCnt);
      aempty_q    <= (count_d <= AemptyCnt);
      overflow_q  <= bus_io.wen && full_q && !bus_io.ren;
      underflow_q <= bus_io.ren && empty_q;
    end
  end

  // Storage is deliberately not reset; reset only gates the write.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem_q[wptr_q] <= bus_io.d;
  end

  assign bus_io.q            = mem_q[rptr_q];
  assign bus_io.count        = count_q;
  assign bus_io.full         = full_q;
  assign bus_io.empty        = empty_q;
  assign bus_io.almost_full  = afull_q;
  assign bus_io.almost_empty = aempty_q;
  assign bus_io.overflow     = overflow_q;
  assign bus_io.underflow    = underflow_q;
endmodule

// File: tb/tb_k_sync_fifo.sv
// Directed bench for k_sync_fifo at DEPTH=4, AFULL_LEVEL=3, AEMPTY_LEVEL=1.
module tb_k_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  k_sync_fifo_if #(.DATA_SIZE(8), .ADDR_SIZE(2)) bus ();

  k_sync_fifo #(
    .DATA_SIZE   (8),
    .ADDR_SIZE   (2),
    .AFULL_LEVEL (3),
    .AEMPTY_LEVEL(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_drain [4];

  initial begin
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    bus.d   = 8'h00;

    // Reset, with a write request that must be ignored
    rst = 1'b1; bus.wen = 1'b1; bus.d = 8'h11;
    cyc();
    rst = 1'b0; bus.wen = 1'b0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_aempty", 32'(bus.almost_empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
    cyc();
    chk("idle_count", 32'(bus.count), 0);

    // Fill
    for (int i = 0; i < 4; i++) begin
      bus.wen = 1'b1; bus.d = 8'hA1 + 8'(i);
      cyc();
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_q", 32'(bus.q), 32'h A1);
      chk("fill_empty", 32'(bus.empty), 0);
      chk("fill_aempty", 32'(bus.almost_empty), (i == 0) ? 32'd1 : 32'd0);
      chk("fill_afull", 32'(bus.almost_full), (i >= 2) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(bus.full), (i == 3) ? 32'd1 : 32'd0);
    end

    // Overflow
    bus.wen = 1'b1; bus.d = 8'hFF; bus.ren = 1'b0;
    cyc();
    bus.wen = 1'b0;
    chk("ovf_pulse", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 4);
    chk("ovf_full", 32'(bus.full), 1);
    cyc();
    chk("ovf_clear", 32'(bus.overflow), 0);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_q", 32'(bus.q), 32'(8'hA1 + 8'(i)));
      bus.ren = 1'b1;
      cyc();
      bus.ren = 1'b0;
      chk("ovf_drain_count", 32'(bus.count), 32'(3 - i));
    end
    chk("ovf_empty", 32'(bus.empty), 1);
    chk("ovf_aempty", 32'(bus.almost_empty), 1);
    chk("ovf_no_unf", 32'(bus.underflow), 0);

    // Full with simultaneous read/write
    for (int i = 0; i < 4; i++) begin
      bus.wen = 1'b1; bus.d = 8'hA1 + 8'(i);
      cyc();
    end
    bus.wen = 1'b1; bus.d = 8'hB5; bus.ren = 1'b1;
    cyc();
    bus.wen = 1'b0; bus.ren = 1'b0;
    chk("fsim_count", 32'(bus.count), 4);
    chk("fsim_full", 32'(bus.full), 1);
    chk("fsim_q", 32'(bus.q), 32'hA2);
    chk("fsim_ovf", 32'(bus.overflow), 0);
    exp_drain[0] = 8'hA2; exp_drain[1] = 8'hA3; exp_drain[2] = 8'hA4; exp_drain[3] = 8'hB5;
    for (int i = 0; i < 4; i++) begin
      chk("fsim_drain_q", 32'(bus.q), 32'(exp_drain[i]));
      bus.ren = 1'b1;
      cyc();
      bus.ren = 1'b0;
    end
    chk("fsim_empty", 32'(bus.empty), 1);

    // Empty with simultaneous read/write: read rejected, write accepted
    bus.wen = 1'b1; bus.d = 8'hC7; bus.ren = 1'b1;
    cyc();
    bus.wen = 1'b0;
    chk("esim_unf", 32'(bus.underflow), 1);
    chk("esim_count", 32'(bus.count), 1);
    chk("esim_q", 32'(bus.q), 32'hC7);
    chk("esim_empty", 32'(bus.empty), 0);
    cyc();
    bus.ren = 1'b0;
    chk("esim_drained", 32'(bus.empty), 1);
    chk("esim_count0", 32'(bus.count), 0);
    chk("esim_unf_clear", 32'(bus.underflow), 0);

    // Streaming across pointer wrap: one in flight, write i while reading i-1
    bus.wen = 1'b1; bus.d = 8'd0;
    cyc();
    for (int i = 1; i < 10; i++) begin
      bus.wen = 1'b1; bus.d = 8'(i); bus.ren = 1'b1;
      chk("wrap_q", 32'(bus.q), 32'(i - 1));
      cyc();
      chk("wrap_count", 32'(bus.count), 1);
    end
    bus.wen = 1'b0;
    chk("wrap_last_q", 32'(bus.q), 9);
    cyc();
    bus.ren = 1'b0;
    chk("wrap_empty", 32'(bus.empty), 1);

    // Reset mid-stream with three words held
    for (int i = 0; i < 3; i++) begin
      bus.wen = 1'b1; bus.d = 8'h31 + 8'(i);
      cyc();
    end
    bus.wen = 1'b0;
    chk("mid_count3", 32'(bus.count), 3);
    chk("mid_afull", 32'(bus.almost_full), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    chk("mid_rst_afull", 32'(bus.almost_full), 0);
    bus.wen = 1'b1; bus.d = 8'h5A;
    cyc();
    bus.wen = 1'b0;
    chk("mid_q", 32'(bus.q), 32'h5A);
    chk("mid_count1", 32'(bus.count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
